// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Issues in-order fetch requests to instruction memory, tracks outstanding
// requests with a small PC queue, buffers returned words, and presents one
// registered {pc, instruction} pair to decode. Redirects kill stale responses
// that are still in flight.
//
// Handshake rules:
//   - Request channel: a transfer happens in a cycle where imem_req_valid and
//     imem_req_ready are both high. While valid is high and ready is low,
//     imem_addr holds steady.
//   - Response channel: valid-only, in order, no back-pressure. Every response
//     matches the oldest outstanding request.
//   - Decode side: decode takes the output pair in a cycle where if_valid is
//     high and stall is low.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        if_valid
);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Fetch-side state
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  kill_q, kill_d;

    // PC queue: addresses of outstanding requests, oldest at the read pointer
    logic [31:0] pcq_q [2];
    logic [31:0] pcq_d [2];
    logic        pcq_wr_q, pcq_wr_d;
    logic        pcq_rd_q, pcq_rd_d;

    // Response buffer: {pc, instruction} pairs waiting for decode
    logic [31:0] buf_pc_q  [2];
    logic [31:0] buf_pc_d  [2];
    logic [31:0] buf_ins_q [2];
    logic [31:0] buf_ins_d [2];
    logic        buf_wr_q, buf_wr_d;
    logic        buf_rd_q, buf_rd_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;

    // Output registers
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;

    // Per-cycle events
    logic [2:0]  occupancy;
    logic        req_fire;
    logic        rsp_fire;
    logic        rsp_kill;
    logic        rsp_live;
    logic [31:0] rsp_pc;
    logic        out_load;
    logic        buf_push;
    logic        buf_pop;

    // Request issue and response classification
    always_comb begin
        occupancy      = {1'b0, inflight_q} + {1'b0, buf_cnt_q};
        // Counting outstanding requests together with buffered words keeps
        // the buffer from ever overflowing, whatever decode does.
        imem_req_valid = !rst && !redirect_valid && (occupancy < 3'd2);
        imem_addr      = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is spurious and ignored.
        rsp_fire       = imem_rsp_valid && (inflight_q != 2'd0);
        rsp_kill       = rsp_fire && (kill_q != 2'd0);
        rsp_live       = rsp_fire && (kill_q == 2'd0) && !redirect_valid;
        rsp_pc         = pcq_q[pcq_rd_q];
        out_load       = !stall || !if_valid_q;
    end

    // Next state for fetch-PC, in-flight count, kill count and PC queue
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        kill_d     = kill_q;
        pcq_d      = pcq_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;

        if (req_fire) begin
            fetch_pc_d        = fetch_pc_q + 32'd4;
            pcq_d[pcq_wr_q]   = fetch_pc_q;
            pcq_wr_d          = ~pcq_wr_q;
        end

        // Every response retires its PC-queue entry, killed or not, so the
        // queue head always matches the next response.
        if (rsp_fire) begin
            pcq_rd_d = ~pcq_rd_q;
        end

        inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, rsp_fire};

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            // Everything still outstanding after this cycle is stale. No
            // request is issued in a redirect cycle, so the in-flight count
            // already includes anything left over from earlier redirects.
            kill_d     = inflight_q - {1'b0, rsp_fire};
        end else if (rsp_kill) begin
            kill_d = kill_q - 2'd1;
        end
    end

    // Next state for response buffer and output registers
    always_comb begin
        buf_pc_d      = buf_pc_q;
        buf_ins_d     = buf_ins_q;
        buf_wr_d      = buf_wr_q;
        buf_rd_d      = buf_rd_q;
        buf_cnt_d     = buf_cnt_q;
        instruction_d = instruction_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        buf_push      = 1'b0;
        buf_pop       = 1'b0;

        if (redirect_valid) begin
            // Redirect flushes everything on the decode side, even under stall.
            buf_wr_d   = 1'b0;
            buf_rd_d   = 1'b0;
            buf_cnt_d  = 2'd0;
            if_valid_d = 1'b0;
        end else begin
            buf_push = rsp_live;
            if (out_load) begin
                if (buf_cnt_q != 2'd0) begin
                    // Oldest buffered word goes first; any live response queues behind it.
                    pc_d          = buf_pc_q[buf_rd_q];
                    instruction_d = buf_ins_q[buf_rd_q];
                    if_valid_d    = 1'b1;
                    buf_pop       = 1'b1;
                end else if (rsp_live) begin
                    // Empty buffer: the response bypasses straight to decode.
                    pc_d          = rsp_pc;
                    instruction_d = imem_rsp_data;
                    if_valid_d    = 1'b1;
                    buf_push      = 1'b0;
                end else begin
                    // Nothing to hand over; keep the stale pair but mark it dead.
                    if_valid_d = 1'b0;
                end
            end

            if (buf_push) begin
                buf_pc_d[buf_wr_q]  = rsp_pc;
                buf_ins_d[buf_wr_q] = imem_rsp_data;
                buf_wr_d            = ~buf_wr_q;
            end
            if (buf_pop) begin
                buf_rd_d = ~buf_rd_q;
            end
            buf_cnt_d = buf_cnt_q + {1'b0, buf_push} - {1'b0, buf_pop};
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 2'd0;
            kill_q        <= 2'd0;
            pcq_wr_q      <= 1'b0;
            pcq_rd_q      <= 1'b0;
            buf_wr_q      <= 1'b0;
            buf_rd_q      <= 1'b0;
            buf_cnt_q     <= 2'd0;
            instruction_q <= NOP_INSN;
            pc_q          <= 32'h0000_0000;
            if_valid_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            buf_wr_q      <= buf_wr_d;
            buf_rd_q      <= buf_rd_d;
            buf_cnt_q     <= buf_cnt_d;
            instruction_q <= instruction_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
        end
    end

    // Queue storage; contents are only meaningful under the pointers/counts
    always_ff @(posedge clk) begin
        pcq_q     <= pcq_d;
        buf_pc_q  <= buf_pc_d;
        buf_ins_q <= buf_ins_d;
    end

    assign instruction = instruction_q;
    assign pc          = pc_q;
    assign if_valid    = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model returning address as data,
// a program-order stream check, and a second instance with a wrapping RESET_PC.
module tb_fetch_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        if_valid;

    // second instance, RESET_PC near the top of the address space
    logic        b_req_valid;
    logic [31:0] b_addr;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic [31:0] b_instruction;
    logic [31:0] b_pc;
    logic        b_if_valid;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .pc             (pc),
        .if_valid       (if_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req_valid (b_req_valid),
        .imem_req_ready (1'b1),
        .imem_addr      (b_addr),
        .imem_rsp_valid (b_rsp_valid),
        .imem_rsp_data  (b_rsp_data),
        .instruction    (b_instruction),
        .pc             (b_pc),
        .if_valid       (b_if_valid)
    );

    // ---------------- scoreboard state ----------------
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];          // expected pc stream of instance b
    logic [31:0] exp_pc = 32'h0;    // next expected pc of the main instance
    int          consumed = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] held_addr = 32'h0;

    // ---------------- memory model ----------------
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc      = 0;
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          rdy_rand = 1'b0;
    int          acc_cnt  = 0;
    bit          b_acc    = 1'b0;
    logic [31:0] b_acc_addr = 32'h0;

    initial begin
        int due;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        b_rsp_valid    = 1'b0;
        b_rsp_data     = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_addr.pop_front();
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            b_rsp_valid    = b_acc;
            b_rsp_data     = b_acc ? b_acc_addr : 32'hDEAD_BEEF;
            @(negedge clk);
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                last_due = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (due <= last_due) due = last_due + 1;
                pend_addr.push_back(imem_addr);
                pend_due.push_back(due);
                last_due = due;
                acc_cnt++;
            end
            b_acc      = b_req_valid && !rst;
            b_acc_addr = b_addr;
        end
    end

    // ---------------- check / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Program-order stream check, run once per cycle at the falling edge.
    task automatic stream_mon();
        if (hold_pend) chk("addr_stable", imem_addr, held_addr);
        hold_pend = 1'b0;
        if (b_if_valid === 1'b1 && exp_q.size() > 0) chk("b_pc", b_pc, exp_q.pop_front());
        if (rst) begin
            exp_pc = 32'h0;
        end else if (redirect_valid) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (if_valid === 1'b1 && !stall) begin
                chk("stream_pc", pc, exp_pc);
                chk("stream_instr", instruction, exp_pc);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (imem_req_valid === 1'b1 && !imem_req_ready) begin
                hold_pend = 1'b1;
                held_addr = imem_addr;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        stream_mon();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc_base;
        int consumed_base;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);

        // reset values
        step();
        step();
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_instruction", instruction, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_b_if_valid", 32'(b_if_valid), 32'h0);

        // latency-1 streaming from RESET_PC
        rst = 1'b0;
        #1;
        chk("c1_req_valid", 32'(imem_req_valid), 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        step();
        chk("c2_if_valid", 32'(if_valid), 32'h0);
        chk("c2_addr", imem_addr, 32'h4);
        step();
        chk("c3_if_valid", 32'(if_valid), 32'h1);
        chk("c3_pc", pc, 32'h0);
        chk("c3_instr", instruction, 32'h0);
        step();
        chk("c4_pc", pc, 32'h4);
        step();
        chk("c5_pc", pc, 32'h8);

        // stall for three cycles with pc=8 on the outputs
        stall    = 1'b1;
        acc_base = acc_cnt;
        step();
        chk("stall_c6_pc", pc, 32'h8);
        chk("stall_c6_if_valid", 32'(if_valid), 32'h1);
        step();
        chk("stall_c7_pc", pc, 32'h8);
        step();
        chk("stall_c8_pc", pc, 32'h8);
        chk("stall_req_bound", 32'((acc_cnt - acc_base) <= 2), 32'h1);
        stall = 1'b0;
        step();
        chk("rel_c9_pc", pc, 32'hC);
        step();
        chk("rel_c10_pc", pc, 32'h10);

        // redirect with two requests in flight (memory latency 3)
        lat_min = 3;
        lat_max = 3;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("two_inflight_req_valid", 32'(imem_req_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("redir_if_valid", 32'(if_valid), 32'h0);
        chk("redir_addr", imem_addr, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("redir_gap_if_valid", 32'(if_valid), 32'h0);
        end
        step();
        chk("redir_first_valid", 32'(if_valid), 32'h1);
        chk("redir_first_pc", pc, 32'h100);
        chk("redir_first_instr", instruction, 32'h100);

        // redirect together with stall; low target bits ignored
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_stall_if_valid", 32'(if_valid), 32'h0);
        chk("redir_stall_addr", imem_addr, 32'h200);
        #1;
        chk("redir_stall_req_valid", 32'(imem_req_valid), 32'h1);
        step();
        step();
        step();
        step();
        chk("redir_stall_pc", pc, 32'h200);
        chk("redir_stall_valid", 32'(if_valid), 32'h1);

        // random ready, latency 1..3, random stall/redirect, reset mid-stream
        lat_min       = 1;
        lat_max       = 3;
        rdy_rand      = 1'b1;
        consumed_base = consumed;
        for (int i = 0; i < 120; i++) begin
            if (i == 60) begin
                rst            = 1'b1;
                stall          = 1'b0;
                redirect_valid = 1'b0;
                step();
                step();
                chk("mid_rst_if_valid", 32'(if_valid), 32'h0);
                chk("mid_rst_instr", instruction, 32'h0000_0013);
                chk("mid_rst_pc", pc, 32'h0);
                rst = 1'b0;
                #1;
                chk("mid_rst_restart_addr", imem_addr, 32'h0);
                consumed_base = consumed;
            end
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = (i != 60) && ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            step();
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk("post_rst_progress", 32'(consumed > consumed_base), 32'h1);
        chk("b_stream_done", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
